// File: rtl/cond_status_unit_if.sv
// Issue/result bundle for the condition/status stage.
// Carries the group, direct status write, flush, result and status.
interface cond_status_unit_if #(
  parameter int LANES = 2
);
  logic               in_valid;
  logic               in_ready;
  logic [LANES-1:0]   in_lane_en;
  logic [4*LANES-1:0] in_cond;
  logic [LANES-1:0]   in_s;
  logic [4*LANES-1:0] in_flags;
  logic               wr_status_en;
  logic [3:0]         wr_status;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [LANES-1:0]   out_exec;
  logic [3:0]         out_status;
  logic [3:0]         status;

  modport master (
    output in_valid, in_lane_en, in_cond,
    output in_s, in_flags,
    output wr_status_en, wr_status,
    output flush, out_ready,
    input  in_ready, out_valid, out_exec,
    input  out_status, status
  );

  modport slave (
    input  in_valid, in_lane_en, in_cond,
    input  in_s, in_flags,
    input  wr_status_en, wr_status,
    input  flush, out_ready,
    output in_ready, out_valid, out_exec,
    output out_status, status
  );
endinterface

// File: rtl/cond_status_unit.sv
// NZCV status register and multi-lane ARM condition evaluation stage.
// Ports: clk, rst_n, bus (slave: issue group in, registered result out).
module cond_status_unit #(
  parameter int          LANES        = 2,
  parameter logic [3:0]  RESET_STATUS = 4'b0000
) (
  input  logic               clk,
  input  logic               rst_n,
  cond_status_unit_if.slave  bus
);

  logic [3:0]       status_q;
  logic [3:0]       out_status_q;
  logic [LANES-1:0] out_exec_q;
  logic             out_valid_q;

  logic [3:0]       s_cur;
  logic [3:0]       s_last;
  logic [LANES-1:0] exec;
  logic             accept;

  // Status is {N,Z,C,V}
  function automatic logic pass(
    input logic [3:0] cond,
    input logic [3:0] s
  );
    logic n, z, c, v, r;
    n = s[3];
    z = s[2];
    c = s[1];
    v = s[0];
    case (cond)
      4'h0:    r = z;
      4'h1:    r = ~z;
      4'h2:    r = c;
      4'h3:    r = ~c;
      4'h4:    r = n;
      4'h5:    r = ~n;
      4'h6:    r = v;
      4'h7:    r = ~v;
      4'h8:    r = c & ~z;
      4'h9:    r = ~c | z;
      4'ha:    r = (n == v);
      4'hb:    r = (n != v);
      4'hc:    r = ~z & (n == v);
      4'hd:    r = z | (n != v);
      4'he:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Flags ripple lane to lane; a direct write lands before lane 0.
  always_comb begin
    exec  = '0;
    s_cur = bus.wr_status_en ? bus.wr_status : status_q;
    for (int i = 0; i < LANES; i++) begin
      exec[i] = bus.in_lane_en[i] &
                pass(bus.in_cond[4*i +: 4], s_cur);
      if (exec[i] & bus.in_s[i])
        s_cur = bus.in_flags[4*i +: 4];
    end
    s_last = s_cur;
  end

  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept = bus.in_valid & bus.in_ready & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q     <= RESET_STATUS;
      out_status_q <= RESET_STATUS;
      out_exec_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      if (accept)
        status_q <= s_last;
      else if (bus.wr_status_en)
        status_q <= bus.wr_status;

      if (accept) begin
        out_valid_q  <= 1'b1;
        out_exec_q   <= exec;
        out_status_q <= s_last;
      end else if (bus.flush | bus.out_ready) begin
        out_valid_q  <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_exec   = out_exec_q;
  assign bus.out_status = out_status_q;
  assign bus.status     = status_q;

endmodule

// File: tb/tb_cond_status_unit.sv
// Directed bench for cond_status_unit, LANES=2, RESET_STATUS=0100.
// Table vectors plus hand-written multi-cycle sequences.
module tb_cond_status_unit;

  localparam int LANES = 2;
  localparam logic [3:0] RST = 4'b0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cond_status_unit_if #(.LANES(LANES)) bus ();

  cond_status_unit #(
    .LANES(LANES),
    .RESET_STATUS(RST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [1:0] en;
    logic [7:0] cond;
    logic [1:0] s;
    logic [7:0] flags;
    logic [3:0] wr;
    logic [1:0] xexec;
    logic [3:0] xstat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_pass(input logic [3:0] c,
                                    input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    if (c == 4'd0)  return z == 1'b1;
    if (c == 4'd1)  return z == 1'b0;
    if (c == 4'd2)  return cy == 1'b1;
    if (c == 4'd3)  return cy == 1'b0;
    if (c == 4'd4)  return n == 1'b1;
    if (c == 4'd5)  return n == 1'b0;
    if (c == 4'd6)  return v == 1'b1;
    if (c == 4'd7)  return v == 1'b0;
    if (c == 4'd8)  return cy && !z;
    if (c == 4'd9)  return !cy || z;
    if (c == 4'd10) return n == v;
    if (c == 4'd11) return n != v;
    if (c == 4'd12) return !z && (n == v);
    if (c == 4'd13) return z || (n != v);
    if (c == 4'd14) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    bus.in_valid     = 1'b0;
    bus.in_lane_en   = '0;
    bus.in_cond      = '0;
    bus.in_s         = '0;
    bus.in_flags     = '0;
    bus.wr_status_en = 1'b0;
    bus.wr_status    = '0;
    bus.flush        = 1'b0;
  endtask

  task automatic group(input logic [1:0] en,
                       input logic [7:0] cond,
                       input logic [1:0] s,
                       input logic [7:0] flags);
    bus.in_valid   = 1'b1;
    bus.in_lane_en = en;
    bus.in_cond    = cond;
    bus.in_s       = s;
    bus.in_flags   = flags;
  endtask

  logic [1:0] hold_exec;
  logic [3:0] hold_stat;

  initial begin
    vecs[0] = '{2'b11, 8'h0E, 2'b01, 8'h04, 4'b0000, 2'b11, 4'b0100};
    vecs[1] = '{2'b11, 8'h11, 2'b01, 8'h00, 4'b0100, 2'b00, 4'b0100};
    vecs[2] = '{2'b01, 8'hEE, 2'b11, 8'h69, 4'b0000, 2'b01, 4'b1001};
    vecs[3] = '{2'b11, 8'h32, 2'b01, 8'h0F, 4'b0000, 2'b10, 4'b0000};
    vecs[4] = '{2'b11, 8'hBC, 2'b11, 8'h28, 4'b1001, 2'b11, 4'b0010};
    vecs[5] = '{2'b11, 8'h98, 2'b01, 8'h06, 4'b0010, 2'b11, 4'b0110};
    vecs[6] = '{2'b11, 8'h6F, 2'b01, 8'h0F, 4'b0001, 2'b10, 4'b0001};
    vecs[7] = '{2'b01, 8'hF6, 2'b00, 8'h00, 4'b0001, 2'b01, 4'b0001};
    vecs[8] = '{2'b11, 8'hDA, 2'b01, 8'h08, 4'b0100, 2'b11, 4'b1000};

    idle();
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_status", 32'(bus.status), 32'(RST));
    chk("rst_out_status", 32'(bus.out_status), 32'(RST));
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_exec", 32'(bus.out_exec), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    rst_n = 1'b1;
    tick();

    // EQ against reset status Z=1
    group(2'b01, 8'h00, 2'b00, 8'h00);
    tick();
    chk("eq_valid", 32'(bus.out_valid), 1);
    chk("eq_exec", 32'(bus.out_exec), 1);
    idle();
    tick();
    chk("eq_drain", 32'(bus.out_valid), 0);

    // table vectors, direct write seeds status each group
    for (int k = 0; k < 9; k++) begin
      group(vecs[k].en, vecs[k].cond, vecs[k].s, vecs[k].flags);
      bus.wr_status_en = 1'b1;
      bus.wr_status    = vecs[k].wr;
      tick();
      chk($sformatf("v%0d_valid", k), 32'(bus.out_valid), 1);
      chk($sformatf("v%0d_exec", k), 32'(bus.out_exec),
          32'(vecs[k].xexec));
      chk($sformatf("v%0d_ostat", k), 32'(bus.out_status),
          32'(vecs[k].xstat));
      chk($sformatf("v%0d_status", k), 32'(bus.status),
          32'(vecs[k].xstat));
    end
    idle();
    tick();

    // every cond against every NZCV, lane 0 only
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        group(2'b01, {4'hF, 4'(c)}, 2'b00, 8'h00);
        bus.wr_status_en = 1'b1;
        bus.wr_status    = 4'(f);
        tick();
        chk($sformatf("cc_c%0d_f%0d", c, f), 32'(bus.out_exec),
            32'({1'b0, ref_pass(4'(c), 4'(f))}));
      end
    end
    idle();
    tick();

    // back-to-back: second group sees first group's flags
    group(2'b01, 8'h0E, 2'b01, 8'h04);
    tick();
    group(2'b01, 8'h00, 2'b00, 8'h00);
    tick();
    chk("b2b_eq_exec", 32'(bus.out_exec), 1);
    group(2'b01, 8'h01, 2'b00, 8'h00);
    tick();
    chk("b2b_ne_exec", 32'(bus.out_exec), 0);
    chk("b2b_status", 32'(bus.status), 32'(4'b0100));
    idle();
    tick();

    // backpressure
    bus.out_ready = 1'b0;
    group(2'b01, 8'h0E, 2'b01, 8'h0A);
    tick();
    chk("bp_valid", 32'(bus.out_valid), 1);
    hold_exec = 2'b01;
    hold_stat = 4'b1010;
    group(2'b01, 8'h0E, 2'b01, 8'h05);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_ready%0d", k), 32'(bus.in_ready), 0);
      chk($sformatf("bp_exec%0d", k), 32'(bus.out_exec),
          32'(hold_exec));
      chk($sformatf("bp_ostat%0d", k), 32'(bus.out_status),
          32'(hold_stat));
      chk($sformatf("bp_status%0d", k), 32'(bus.status),
          32'(hold_stat));
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 1);
    tick();
    chk("bp_next_valid", 32'(bus.out_valid), 1);
    chk("bp_next_ostat", 32'(bus.out_status), 32'(4'b0101));
    chk("bp_next_status", 32'(bus.status), 32'(4'b0101));
    idle();
    tick();

    // flush drops the offered group
    group(2'b01, 8'h0E, 2'b01, 8'h0F);
    bus.flush = 1'b1;
    tick();
    chk("fl_valid", 32'(bus.out_valid), 0);
    chk("fl_status", 32'(bus.status), 32'(4'b0101));
    // flush with a direct write: write still lands
    bus.wr_status_en = 1'b1;
    bus.wr_status    = 4'b0011;
    tick();
    chk("fl_wr_status", 32'(bus.status), 32'(4'b0011));
    chk("fl_wr_valid", 32'(bus.out_valid), 0);
    idle();
    tick();

    // flush kills a pending stalled result
    bus.out_ready = 1'b0;
    group(2'b01, 8'h0E, 2'b00, 8'h00);
    tick();
    idle();
    bus.flush = 1'b1;
    tick();
    chk("fl_kill_valid", 32'(bus.out_valid), 0);
    idle();
    bus.out_ready = 1'b1;
    tick();

    // reset in the middle of a stall
    bus.out_ready = 1'b0;
    group(2'b01, 8'h0E, 2'b01, 8'h09);
    tick();
    idle();
    chk("rs_pre_valid", 32'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_valid", 32'(bus.out_valid), 0);
    chk("rs_status", 32'(bus.status), 32'(RST));
    chk("rs_exec", 32'(bus.out_exec), 0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
